// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : life_pkg
//  Purpose  : Shared definitions for the life frame scanner: board and tile
//             geometry, tile selector encodings and the scanner FSM state type.
//  Ports    : (package, no ports)
//  Revision : 1.0  initial release
// ============================================================================
package life_pkg;

    // Board is 8x8 cells, built from four 4x4 tiles.
    localparam int BOARD_DIM  = 8;
    localparam int TILE_DIM   = 4;
    localparam int TILE_BITS  = TILE_DIM * TILE_DIM;
    localparam int NUM_TILES  = 4;
    localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM;

    // Tile selector encoding is {east_half, south_half}.
    localparam logic [1:0] TILE_TL = 2'b00;
    localparam logic [1:0] TILE_BL = 2'b01;
    localparam logic [1:0] TILE_TR = 2'b10;
    localparam logic [1:0] TILE_BR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : life_pkg
`default_nettype wire

// File: rtl/life_row_mux.sv
`default_nettype none
// ============================================================================
//  Module   : life_row_mux
//  Purpose  : Combinational extraction of one 8-cell board row from the 64-bit
//             frame buffer, which holds the four tiles back to back
//             (tile index * 16 + tile bit).
//  Ports    : frame    [63:0] in  - frame buffer, tile t at bits [16t+15:16t]
//             row_sel  [2:0]  in  - board row to extract (0 = north)
//             row_data [7:0]  out - bit c = column c (0 = west)
//  Revision : 1.0  initial release
// ============================================================================
module life_row_mux
    import life_pkg::*;
(
    input  logic [BOARD_BITS-1:0] frame,
    input  logic [2:0]            row_sel,
    output logic [BOARD_DIM-1:0]  row_data
);

    // Cell (r,c) lives in tile {c[2], r[2]} at tile bit 4*c[1:0] + r[1:0],
    // so its frame index is simply the concatenation of those fields.
    for (genvar gc = 0; gc < BOARD_DIM; gc++) begin : g_col
        localparam logic [2:0] c_col = 3'(gc);
        assign row_data[gc] = frame[{c_col[2], row_sel[2], c_col[1:0], row_sel[1:0]}];
    end

endmodule : life_row_mux
`default_nettype wire

// File: rtl/life_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : life_frame_scanner
//  Purpose  : Reads the four 4x4 tiles of an 8x8 life array into a frame
//             buffer, streams the board out row by row over a valid/ready
//             handshake, reports whether the generation changed, and
//             optionally pulses step to advance the array.
//  Ports    : clk, reset            - clock, async active-high reset
//             start                 - request one frame scan (IDLE only)
//             step_enable           - pulse step at end of each frame
//             valo, valo_prev [15:0]- selected tile, current / previous gen
//             valo_selector [1:0]   - tile select 00 TL, 01 BL, 10 TR, 11 BR
//             step                  - generation-advance pulse
//             row_data [7:0], row_idx [2:0], row_valid, row_ready
//                                   - row stream
//             frame_done            - end-of-frame pulse
//             frame_stable          - last frame had no change on any tile
//  Revision : 1.0  initial release
// ============================================================================
module life_frame_scanner
    import life_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1     // legal 1..15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step_enable,
    input  logic [TILE_BITS-1:0]  valo,
    input  logic [TILE_BITS-1:0]  valo_prev,
    output logic [1:0]            valo_selector,
    output logic                  step,
    output logic [BOARD_DIM-1:0]  row_data,
    output logic [2:0]            row_idx,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic                  frame_done,
    output logic                  frame_stable
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [1:0]             r_tile;
    logic [3:0]             r_settle;
    logic [2:0]             r_row;
    logic [BOARD_BITS-1:0]  r_frame;
    logic                   r_changed;
    logic                   r_stable;
    logic [BOARD_DIM-1:0]   w_row_data;

    logic w_tile_last;
    logic w_load_last;
    logic w_row_xfer;
    logic w_frame_last;

    assign w_tile_last  = (r_settle == 4'(SETTLE_CYCLES - 1));
    assign w_load_last  = w_tile_last && (r_tile == TILE_BR);
    // Derived from the state register rather than row_valid so that the
    // next-state logic does not read back its own outputs.
    assign w_row_xfer   = (r_state == EMIT) && row_ready;
    assign w_frame_last = w_row_xfer && (r_row == 3'd7);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        row_valid    = 1'b0;
        frame_done   = 1'b0;
        step         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                if (w_load_last) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                row_valid = 1'b1;
                if (w_frame_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                frame_done   = 1'b1;
                step         = step_enable;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: tile sequencing, frame buffer, change flag, row counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tile    <= TILE_TL;
            r_settle  <= '0;
            r_row     <= '0;
            r_frame   <= '0;
            r_changed <= 1'b0;
            r_stable  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tile    <= TILE_TL;
                        r_settle  <= '0;
                        r_row     <= '0;
                        r_changed <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_tile_last) begin
                        // Sample on the last edge of the settle window; the
                        // tile counter wraps back to TL after BR.
                        r_frame[{r_tile, 4'b0000} +: TILE_BITS] <= valo;
                        r_changed <= r_changed | (|(valo ^ valo_prev));
                        r_settle  <= '0;
                        r_tile    <= r_tile + 2'd1;
                    end else begin
                        r_settle  <= r_settle + 4'd1;
                    end
                end
                EMIT: begin
                    if (w_row_xfer) begin
                        r_row <= r_row + 3'd1;
                    end
                end
                DONE: begin
                    r_stable <= ~r_changed;
                end
                default: begin
                    r_row <= '0;
                end
            endcase
        end
    end

    life_row_mux u_row_mux (
        .frame    (r_frame),
        .row_sel  (r_row),
        .row_data (w_row_data)
    );

    assign valo_selector = r_tile;
    assign row_idx       = r_row;
    assign row_data      = row_valid ? w_row_data : '0;
    assign frame_stable  = r_stable;

endmodule : life_frame_scanner
`default_nettype wire

// File: tb/tb_life_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_life_frame_scanner
//  Purpose  : Self-checking bench for life_frame_scanner: table of tile
//             patterns with hand-computed rows, plus reset / abort sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_life_frame_scanner;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        step_enable;
    logic [15:0] valo;
    logic [15:0] valo_prev;
    logic [1:0]  valo_selector;
    logic        step;
    logic [7:0]  row_data;
    logic [2:0]  row_idx;
    logic        row_valid;
    logic        row_ready;
    logic        frame_done;
    logic        frame_stable;

    int total = 0;
    int bad   = 0;
    logic last_stable = 1'b0;

    always #5 clk = ~clk;

    life_frame_scanner #(.SETTLE_CYCLES(S)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .step_enable   (step_enable),
        .valo          (valo),
        .valo_prev     (valo_prev),
        .valo_selector (valo_selector),
        .step          (step),
        .row_data      (row_data),
        .row_idx       (row_idx),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .frame_done    (frame_done),
        .frame_stable  (frame_stable)
    );

    // Array model: the selected tile shows garbage for the first cycle after
    // the selector changes, so only a properly settled sample is correct.
    logic [3:0][15:0] tiles_cur;
    logic [3:0][15:0] tiles_prev;
    logic [1:0]       sel_q = 2'b00;
    always @(posedge clk) sel_q <= valo_selector;
    assign valo      = (valo_selector != sel_q) ? ~tiles_cur[valo_selector]
                                                : tiles_cur[valo_selector];
    assign valo_prev = tiles_prev[valo_selector];

    typedef struct packed {
        logic [3:0][15:0] cur;     // index = tile selector
        logic [3:0][15:0] prev;
        logic             step_en;
        logic [7:0][7:0]  rows;    // rows[r] = expected row r
        logic             stable;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [15:0] tl, bl, tr, br,
                                input logic [15:0] ptl, pbl, ptr, pbr,
                                input logic se, input logic [63:0] rows,
                                input logic st);
        vec_t v;
        v.cur     = {br, tr, bl, tl};
        v.prev    = {pbr, ptr, pbl, ptl};
        v.step_en = se;
        v.rows    = rows;
        v.stable  = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},    64'(valo_selector), 64'd0);
        chk({tag, "_step"},   64'(step),          64'd0);
        chk({tag, "_data"},   64'(row_data),      64'd0);
        chk({tag, "_idx"},    64'(row_idx),       64'd0);
        chk({tag, "_valid"},  64'(row_valid),     64'd0);
        chk({tag, "_done"},   64'(frame_done),    64'd0);
        chk({tag, "_stable"}, 64'(frame_stable),  64'd0);
    endtask

    // Runs one frame from a start pulse, checking selector timing, the row
    // stream, latency, step/frame_done pulses and the stable flag.
    task automatic run_frame(input vec_t v, input int stall_len, input bit poke_start);
        int  next_row;
        int  stall_left;
        int  steps;
        int  dones;
        int  done_n;
        bit  poked;
        tiles_cur   = v.cur;
        tiles_prev  = v.prev;
        step_enable = v.step_en;
        row_ready   = 1'b1;
        next_row    = 0;
        stall_left  = stall_len;
        steps       = 0;
        dones       = 0;
        done_n      = -1;
        poked       = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 4*S + 8 + stall_len + 4*S + 4; n++) begin
            start = 1'b0;
            if (n == 0) chk("stable_hold", 64'(frame_stable), 64'(last_stable));
            if (n < 4*S) begin
                chk("load_sel", 64'(valo_selector), 64'(n / S));
                chk("load_valid", 64'(row_valid), 64'd0);
            end
            if (done_n >= 0 && n > done_n) begin
                chk("post_valid", 64'(row_valid), 64'd0);
                chk("post_sel", 64'(valo_selector), 64'd0);
            end
            if (row_valid) begin
                if (next_row > 7) begin
                    chk("extra_row", 64'(next_row), 64'd7);
                    row_ready = 1'b1;
                end else begin
                    chk("row_idx", 64'(row_idx), 64'(next_row));
                    chk("row_data", 64'(row_data), 64'(v.rows[next_row]));
                    if (next_row == 2 && stall_left > 0) begin
                        row_ready = 1'b0;
                        stall_left--;
                    end else begin
                        row_ready = 1'b1;
                        next_row++;
                    end
                end
                if (poke_start && !poked) begin
                    start = 1'b1;
                    poked = 1'b1;
                end
            end else begin
                row_ready = 1'b1;
            end
            if (frame_done) begin
                dones++;
                if (done_n < 0) done_n = n;
            end
            if (step) begin
                steps++;
                if (!frame_done) chk("step_outside_done", 64'(step), 64'd0);
            end
            @(negedge clk);
        end
        start     = 1'b0;
        row_ready = 1'b1;
        chk("rows_seen", 64'(next_row), 64'd8);
        chk("done_count", 64'(dones), 64'd1);
        chk("step_count", 64'(steps), 64'(v.step_en));
        chk("latency", 64'(done_n + 1), 64'(4*S + 8 + 1 + stall_len));
        chk("frame_stable", 64'(frame_stable), 64'(v.stable));
        last_stable = v.stable;
    endtask

    // Starts a frame and asserts reset after abort_n observed cycles, or
    // once row 3 is on the bus when abort_n is negative.
    task automatic abort_frame(input vec_t v, input int abort_n, input string tag);
        bit found;
        bit quiet;
        tiles_cur   = v.cur;
        tiles_prev  = v.prev;
        step_enable = v.step_en;
        row_ready   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (abort_n < 0 ? (row_valid && row_idx == 3'd3) : (k == abort_n)) found = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_reached"}, 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        chk_all_zero({tag, "_async"});
        @(negedge clk);
        chk_all_zero({tag, "_held"});
        reset = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 4*S + 12; k++) begin
            @(negedge clk);
            if (step || frame_done || row_valid || valo_selector != 2'b00) quiet = 1'b0;
        end
        chk({tag, "_quiet"}, 64'(quiet), 64'd1);
        last_stable = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b1;
        step_enable = 1'b1;
        row_ready   = 1'b1;
        tiles_cur   = '0;
        tiles_prev  = '0;

        repeat (2) begin
            @(negedge clk);
            chk_all_zero("reset");
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", 64'(row_valid), 64'd0);
            chk("idle_sel", 64'(valo_selector), 64'd0);
        end

        //              TL       BL       TR       BR       pTL      pBL      pTR      pBR    se  rows                     stable
        vecs[0] = mk(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 64'h00000000_00000001, 1'b1);
        vecs[1] = mk(16'h8000, 16'h1000, 16'h0008, 16'h0001, 16'h8000, 16'h1000, 16'h0008, 16'h0001, 1'b0, 64'h00000018_18000000, 1'b1);
        vecs[2] = mk(16'h0000, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 64'h00000000_10000000, 1'b0);
        vecs[3] = mk(16'h0000, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 64'h00000000_10000000, 1'b0);
        vecs[4] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 64'hF0F0F0F0_0F0F0F0F, 1'b1);
        vecs[5] = mk(16'h000F, 16'hF000, 16'h0010, 16'h0000, 16'h000F, 16'hF000, 16'h0010, 16'h0000, 1'b0, 64'h08080808_01010121, 1'b1);
        vecs[6] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0, 64'h00000000_00000000, 1'b0);
        vecs[7] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 64'h00000000_00000000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i], (i == 5) ? 3 : 0, (i == 2));
        end

        // Abort mid-EMIT and mid-LOAD, then a clean frame proves recovery.
        abort_frame(vecs[4], -1, "abort_emit");
        abort_frame(vecs[2], 3, "abort_load");
        run_frame(vecs[1], 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_life_frame_scanner
`default_nettype wire

// File: doc/life_frame_scanner.md
LIFE_FRAME_SCANNER -- requirements
Module: life_frame_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: cycles valo_selector is held before valo is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock for all state, rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to scan one frame; ignored unless in IDLE.
REQ-005 step_enable  input  1  when high, step is pulsed after each completed frame.
REQ-006 valo  input  16  current 4x4 tile contents from the 8x8 array, selected by valo_selector.
REQ-007 valo_prev  input  16  previous-generation contents of the same tile.
REQ-008 valo_selector  output  2  tile select: 00 TL, 01 BL, 10 TR, 11 BR.
REQ-009 step  output  1  one-cycle generation-advance pulse to the array.
REQ-010 row_data  output  8  one board row; bit c = column c, col 0 = west.
REQ-011 row_idx  output  3  row number of row_data; row 0 = north.
REQ-012 row_valid / row_ready  output / input  1 each  row stream handshake.
REQ-013 frame_done  output  1  one-cycle pulse at end of frame.
REQ-014 frame_stable  output  1  held high when the last frame showed valo == valo_prev on all four tiles.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, EMIT, DONE.
REQ-016 IDLE -> LOAD on start=1; valo_selector SHALL be 00 in the first LOAD cycle.
REQ-017 LOAD SHALL visit tiles in order 00, 01, 10, 11; each tile holds valo_selector for exactly SETTLE_CYCLES cycles and samples valo and valo_prev on the last of those edges.
REQ-018 LOAD SHALL last 4*SETTLE_CYCLES cycles, then -> EMIT.
REQ-019 Tile bit mapping: tile bit index = 4*local_col + local_row, bit 0 = tile's NW cell.
REQ-020 Board cell (r,c) SHALL come from tile {c>=4, r>=4}, local_row = r mod 4, local_col = c mod 4.
REQ-021 EMIT SHALL present rows 0..7 in order; row_valid high from the first EMIT cycle; row advances only on a cycle with row_valid & row_ready.
REQ-022 row_data and row_idx SHALL stay stable while row_valid=1 and row_ready=0.
REQ-023 The row-7 handshake SHALL go to DONE; row_valid drops in the DONE cycle.
REQ-024 DONE lasts one cycle: frame_done=1, step=step_enable, then -> IDLE.
REQ-025 frame_stable SHALL update in DONE to NOT(OR over tiles of (valo XOR valo_prev)) and hold until the next DONE.
REQ-026 step SHALL be 0 in every state other than DONE.
REQ-027 start during LOAD, EMIT or DONE SHALL be ignored, not queued.
REQ-028 Minimum frame latency, start to frame_done: 4*SETTLE_CYCLES + 8 + 1 cycles with row_ready held high.

Reset
REQ-029 Reset SHALL force IDLE, clear the 64-bit frame buffer and the change flag, and clear the row counter.
REQ-030 Under reset all outputs SHALL be 0: valo_selector=00, step, row_data, row_idx, row_valid, frame_done, frame_stable.
REQ-031 Reset asserted mid-LOAD or mid-EMIT SHALL abort the frame with no step or frame_done pulse.

Structure
REQ-032 The shared package life_pkg SHALL hold the tile selector constants TILE_TL/BL/TR/BR, the FSM state type, and the board/tile dimension constants.
REQ-033 One sub-module, life_row_mux, SHALL perform the combinational frame-buffer-to-row mapping (REQ-019/020).

Verification
REQ-034 Reset: hold reset 2 cycles -> all outputs 0 and state IDLE, even with start=1.
REQ-035 Single corner: valo=0x0001 on sel 00, 0 elsewhere, valo_prev equal -> row0=0x01, rows1-7=0x00, frame_stable=1.
REQ-036 Centre block: TL=0x8000, BL=0x1000, TR=0x0008, BR=0x0001 -> row3=0x18, row4=0x18, all other rows 0x00.
REQ-037 Backpressure: row_ready low 3 cycles during row 2 -> row_valid=1, row_idx=2, row_data unchanged, then the stream resumes in order.
REQ-038 Change and step: valo_prev differs on tile 10 with step_enable=1 -> frame_stable=0, and step plus frame_done each high for exactly one cycle after the row-7 handshake; with step_enable=0, step stays 0.
REQ-039 Abort and ignore: start pulsed during EMIT -> no second frame; reset asserted mid-EMIT -> next cycle row_valid=0, IDLE, and no step pulse.
